// File: rtl/tlul_host_adapter.sv
// Host-side TL-UL bridge: turns a req/gnt register-style port into single-outstanding TL-UL requests.
// Latency: grant in cycle 0, A-channel in cycle 1, response pulse on the same cycle as d_valid (best case cycle 2).
// Backpressure: A fields are held until a_ready; no new grant until the response has been returned.

package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tlul_d2h_t;

endpackage

module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned SourceId = 0,
  parameter bit          CheckRsp = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output tlul_h2d_t   tl_o,
  input  tlul_d2h_t   tl_i
);

  localparam logic [7:0] SrcId = 8'(SourceId);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

  state_e      state;
  logic        a_valid_q;
  logic        d_ready_q;
  logic        get_q;
  logic [2:0]  opcode_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  mask_q;
  logic [2:0]  exp_opcode;
  logic        rsp_mismatch;

  // Fields the adapter never looks at; kept in one place so they are visibly ignored.
  logic unused_sig;
  assign unused_sig = ^{addr_i[1:0], tl_i.d_param, tl_i.d_size, tl_i.d_sink};

  // Grant and response are combinational so a held request and a same-cycle response need no extra cycle.
  assign gnt_o   = (state == IDLE) & req_i;
  assign valid_o = (state == RSP) & tl_i.d_valid;

  // Transaction sequencing: capture the request, hold A until accepted, then wait for D.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      a_valid_q <= 1'b0;
      d_ready_q <= 1'b0;
      get_q     <= 1'b0;
      opcode_q  <= 3'h0;
      addr_q    <= 32'h0;
      data_q    <= 32'h0;
      mask_q    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            state     <= REQ;
            a_valid_q <= 1'b1;
            get_q     <= !we_i;
            addr_q    <= {addr_i[31:2], 2'b00};
            data_q    <= we_i ? wdata_i : 32'h0;
            if (!we_i) begin
              opcode_q <= Get;
              // A read with no lanes enabled is widened to a full-word read.
              mask_q   <= (be_i == 4'h0) ? 4'hF : be_i;
            end else begin
              opcode_q <= (be_i == 4'hF) ? PutFullData : PutPartialData;
              mask_q   <= be_i;
            end
          end
        end
        REQ: begin
          if (tl_i.a_ready) begin
            state     <= RSP;
            a_valid_q <= 1'b0;
            d_ready_q <= 1'b1;
          end
        end
        RSP: begin
          if (tl_i.d_valid) begin
            state     <= IDLE;
            d_ready_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          a_valid_q <= 1'b0;
          d_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Response checking against what this request should have produced.
  assign exp_opcode   = get_q ? AccessAckData : AccessAck;
  assign rsp_mismatch = (tl_i.d_source != SrcId) | (tl_i.d_opcode != exp_opcode);
  assign err_o        = valid_o & (tl_i.d_error | (CheckRsp & rsp_mismatch));
  assign rdata_o      = valid_o ? tl_i.d_data : 32'h0;

  // A-channel fields come straight from the capture registers so they stay stable while a_valid is high.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid_q;
    tl_o.a_opcode  = opcode_q;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = SrcId;
    tl_o.a_address = addr_q;
    tl_o.a_mask    = mask_q;
    tl_o.a_data    = data_q;
    tl_o.d_ready   = d_ready_q;
  end

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Bench for tlul_host_adapter: directed scenarios with literal expectations, then randomized traffic.
// A protocol-level model (busy / A-accepted flags plus the expected A fields) is compared every cycle.
module tb_tlul_host_adapter;
  import tlul_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        vld;
  logic [31:0] rdata;
  logic        err;
  tlul_h2d_t   tl_h;
  tlul_d2h_t   tl_d;

  int checks = 0;
  int passes = 0;

  // Model state: a transaction granted and not yet answered, and whether its A beat was accepted.
  logic        m_busy = 1'b0;
  logic        m_adone = 1'b0;
  logic        m_get = 1'b0;
  logic [2:0]  m_op = 3'h0;
  logic [31:0] m_addr = 32'h0;
  logic [3:0]  m_mask = 4'h0;
  logic [31:0] m_data = 32'h0;

  always #5 clk = ~clk;

  tlul_host_adapter #(.SourceId(0), .CheckRsp(1'b1)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .gnt_o   (gnt),
    .addr_i  (addr),
    .we_i    (we),
    .wdata_i (wdata),
    .be_i    (be),
    .valid_o (vld),
    .rdata_o (rdata),
    .err_o   (err),
    .tl_o    (tl_h),
    .tl_i    (tl_d)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic host(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] b);
    req = 1'b1; addr = a; we = w; wdata = wd; be = b;
  endtask

  task automatic rsp(input logic [2:0] op, input logic [7:0] src, input logic e, input logic [31:0] d);
    tl_d.d_valid = 1'b1; tl_d.d_opcode = op; tl_d.d_source = src; tl_d.d_error = e; tl_d.d_data = d;
  endtask

  // Per-cycle comparison against the model, then advance the model to what the next edge produces.
  always @(negedge clk) begin
    logic        e_gnt, e_av, e_dr, e_vld, e_err;
    logic [31:0] e_rd;
    if (!rst_n) begin
      chk("rst_gnt", 32'(gnt), 32'(req));
      chk("rst_valid", 32'(vld), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_a_valid", 32'(tl_h.a_valid), 0);
      chk("rst_d_ready", 32'(tl_h.d_ready), 0);
      chk("rst_a_address", tl_h.a_address, 0);
      chk("rst_a_mask", 32'(tl_h.a_mask), 0);
      chk("rst_a_data", tl_h.a_data, 0);
      m_busy  = 1'b0;
      m_adone = 1'b0;
    end else begin
      e_gnt = !m_busy && req;
      e_av  = m_busy && !m_adone;
      e_dr  = m_busy && m_adone;
      e_vld = e_dr && tl_d.d_valid;
      e_err = e_vld && (tl_d.d_error || tl_d.d_source != 8'd0 ||
                        tl_d.d_opcode != (m_get ? 3'h1 : 3'h0));
      e_rd  = e_vld ? tl_d.d_data : 32'h0;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("a_valid", 32'(tl_h.a_valid), 32'(e_av));
      chk("d_ready", 32'(tl_h.d_ready), 32'(e_dr));
      chk("valid", 32'(vld), 32'(e_vld));
      chk("err", 32'(err), 32'(e_err));
      chk("rdata", rdata, e_rd);
      if (e_av) begin
        chk("a_opcode", 32'(tl_h.a_opcode), 32'(m_op));
        chk("a_address", tl_h.a_address, m_addr);
        chk("a_mask", 32'(tl_h.a_mask), 32'(m_mask));
        chk("a_data", tl_h.a_data, m_data);
        chk("a_size", 32'(tl_h.a_size), 2);
        chk("a_source", 32'(tl_h.a_source), 0);
        chk("a_param", 32'(tl_h.a_param), 0);
      end
      if (e_gnt) begin
        m_busy  = 1'b1;
        m_adone = 1'b0;
        m_get   = !we;
        m_op    = !we ? 3'h4 : (be == 4'hF ? 3'h0 : 3'h1);
        m_addr  = addr & 32'hFFFF_FFFC;
        m_mask  = (!we && be == 4'h0) ? 4'hF : be;
        m_data  = we ? wdata : 32'h0;
      end else if (e_av && tl_d.a_ready) begin
        m_adone = 1'b1;
      end else if (e_vld) begin
        m_busy  = 1'b0;
        m_adone = 1'b0;
      end
    end
  end

  task automatic quiet();
    req = 1'b0; tl_d.a_ready = 1'b0; tl_d.d_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0; addr = 32'h0; we = 1'b0; wdata = 32'h0; be = 4'h0;
    tl_d = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Read with best-case device timing.
    host(32'h1000_0104, 1'b0, 32'h0, 4'hF);
    sample(); chk("rd_gnt", 32'(gnt), 1);
    step(); req = 1'b0; tl_d.a_ready = 1'b1;
    sample();
    chk("rd_a_valid", 32'(tl_h.a_valid), 1);
    chk("rd_a_opcode", 32'(tl_h.a_opcode), 32'h4);
    chk("rd_a_address", tl_h.a_address, 32'h1000_0104);
    chk("rd_a_size", 32'(tl_h.a_size), 2);
    chk("rd_a_mask", 32'(tl_h.a_mask), 32'hF);
    step(); tl_d.a_ready = 1'b0; rsp(AccessAckData, 8'd0, 1'b0, 32'hDEAD_BEEF);
    sample();
    chk("rd_valid", 32'(vld), 1);
    chk("rd_rdata", rdata, 32'hDEAD_BEEF);
    chk("rd_err", 32'(err), 0);
    step(); quiet();
    sample(); chk("rd_valid_pulse", 32'(vld), 0);

    // Partial write to an unaligned address.
    step(); host(32'h2000_0003, 1'b1, 32'h1234_5678, 4'b0011);
    step(); req = 1'b0; tl_d.a_ready = 1'b1;
    sample();
    chk("pw_a_opcode", 32'(tl_h.a_opcode), 32'h1);
    chk("pw_a_mask", 32'(tl_h.a_mask), 32'h3);
    chk("pw_a_data", tl_h.a_data, 32'h1234_5678);
    chk("pw_a_address", tl_h.a_address, 32'h2000_0000);
    step(); tl_d.a_ready = 1'b0; rsp(AccessAck, 8'd0, 1'b0, 32'h0);
    sample();
    chk("pw_valid", 32'(vld), 1);
    chk("pw_err", 32'(err), 0);
    step(); quiet();

    // Backpressure with a second request held pending; first response carries d_error.
    step(); host(32'h3000_0008, 1'b1, 32'hAABB_CCDD, 4'hF);
    step(); host(32'h4000_0010, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("bp_a_valid", 32'(tl_h.a_valid), 1);
      chk("bp_gnt", 32'(gnt), 0);
      chk("bp_a_address", tl_h.a_address, 32'h3000_0008);
      chk("bp_a_data", tl_h.a_data, 32'hAABB_CCDD);
      chk("bp_a_opcode", 32'(tl_h.a_opcode), 32'h0);
      step();
    end
    tl_d.a_ready = 1'b1;
    sample(); chk("bp_gnt_acc", 32'(gnt), 0);
    step(); tl_d.a_ready = 1'b0; rsp(AccessAck, 8'd0, 1'b1, 32'h0);
    sample();
    chk("derr_valid", 32'(vld), 1);
    chk("derr_err", 32'(err), 1);
    chk("derr_gnt", 32'(gnt), 0);
    step(); tl_d.d_valid = 1'b0;
    sample(); chk("held_req_gnt", 32'(gnt), 1);
    step(); req = 1'b0; tl_d.a_ready = 1'b1;
    sample();
    chk("be0_a_mask", 32'(tl_h.a_mask), 32'hF);
    chk("be0_a_opcode", 32'(tl_h.a_opcode), 32'h4);
    step(); tl_d.a_ready = 1'b0; rsp(AccessAck, 8'd0, 1'b0, 32'h0);
    sample(); chk("opc_err", 32'(err), 1);
    step(); quiet(); host(32'h5000_0000, 1'b0, 32'h0, 4'hF);
    step(); req = 1'b0; tl_d.a_ready = 1'b1;
    step(); tl_d.a_ready = 1'b0; rsp(AccessAckData, 8'd5, 1'b0, 32'h1);
    sample(); chk("src_err", 32'(err), 1);
    step(); quiet();

    // Reset while waiting for the response; stale d_valid afterwards.
    step(); host(32'h6000_0000, 1'b0, 32'h0, 4'hF);
    step(); req = 1'b0; tl_d.a_ready = 1'b1;
    step(); tl_d.a_ready = 1'b0;
    sample(); chk("rsp_d_ready", 32'(tl_h.d_ready), 1);
    step(); rst_n = 1'b0; rsp(AccessAckData, 8'd0, 1'b0, 32'h55);
    sample();
    chk("rstrsp_a_valid", 32'(tl_h.a_valid), 0);
    chk("rstrsp_d_ready", 32'(tl_h.d_ready), 0);
    chk("rstrsp_valid", 32'(vld), 0);
    step(); rst_n = 1'b1;
    sample();
    chk("stale_d_ready", 32'(tl_h.d_ready), 0);
    chk("stale_valid", 32'(vld), 0);
    step(); quiet();

    // Randomized traffic, with the device also emitting stray and malformed responses.
    for (int c = 0; c < 3000; c++) begin
      step();
      req   = ($urandom_range(0, 2) != 0);
      addr  = $urandom;
      we    = $urandom_range(0, 1) == 1;
      wdata = $urandom;
      case ($urandom_range(0, 3))
        0:       be = 4'hF;
        1:       be = 4'h0;
        default: be = 4'($urandom_range(0, 15));
      endcase
      tl_d.a_ready  = $urandom_range(0, 1) == 1;
      tl_d.d_valid  = $urandom_range(0, 9) < 4;
      tl_d.d_data   = $urandom;
      tl_d.d_error  = $urandom_range(0, 15) == 0;
      tl_d.d_source = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      tl_d.d_opcode = ($urandom_range(0, 9) < 8) ? (m_get ? AccessAckData : AccessAck)
                                                 : 3'($urandom_range(0, 7));
      tl_d.d_param  = 3'($urandom_range(0, 7));
      tl_d.d_size   = 2'($urandom_range(0, 3));
      tl_d.d_sink   = $urandom_range(0, 1) == 1;
    end
    step(); quiet();
    sample();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
